// File: rtl/commit_trace_monitor_if.sv
// commit_trace_monitor_if: retirement strobe, trace read port and status outputs of the commit monitor
interface commit_trace_monitor_if #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
);
    logic                       clr;
    logic                       insn_vld;
    logic [PC_W-1:0]            pc;
    logic [$clog2(DEPTH)-1:0]   trace_idx;
    logic [1:0]                 state;
    logic                       halted;
    logic                       timeout;
    logic [CNT_W-1:0]           insn_cnt;
    logic [CNT_W-1:0]           cycle_cnt;
    logic [PC_W-1:0]            signature;
    logic [PC_W-1:0]            trace_pc;
    logic [$clog2(DEPTH):0]     trace_cnt;
    modport master (
        output clr, insn_vld, pc, trace_idx,
        input  state, halted, timeout, insn_cnt, cycle_cnt, signature, trace_pc, trace_cnt
    );
    modport slave (
        input  clr, insn_vld, pc, trace_idx,
        output state, halted, timeout, insn_cnt, cycle_cnt, signature, trace_pc, trace_cnt
    );
endinterface

// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor: halt/timeout detection, counters, PC signature and trace of recent retirements
module commit_trace_monitor #(
    parameter int              PC_W        = 32,
    parameter int              DEPTH       = 8,
    parameter int              CNT_W       = 32,
    parameter int              HALT_REPEAT = 4,
    parameter int              TIMEOUT_CYC = 1024,
    parameter logic [PC_W-1:0] SIG_SEED    = '0
) (
    input logic                  clk,
    input logic                  rst,
    commit_trace_monitor_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int RW = $clog2(HALT_REPEAT + 1);
    localparam int SW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALTED = 2'b10, TIMEOUT = 2'b11} state_t;

    state_t          state, state_nxt;
    logic            halted, timeout, active, count, last_vld;
    logic [RW-1:0]   rep, rep_nxt;
    logic [SW-1:0]   stall, stall_nxt;
    logic [CNT_W-1:0] insn_cnt, cycle_cnt;
    logic [PC_W-1:0] signature, last_pc;
    logic [PC_W-1:0] trace [DEPTH];
    logic [IW-1:0]   wr_ptr, rd_ptr;
    logic [IW:0]     trace_cnt;

    assign active    = state == IDLE || state == RUN;
    assign count     = active && bus.insn_vld;
    // last_vld keeps the very first retirement from matching a reset-valued last_pc
    assign rep_nxt   = (last_vld && bus.pc == last_pc) ? rep + 1'b1 : '0;
    assign stall_nxt = stall + 1'b1;

    always_comb begin
        state_nxt = state;
        if (bus.clr)
            state_nxt = IDLE;
        else if (count)
            state_nxt = (state == RUN && rep_nxt == RW'(HALT_REPEAT)) ? HALTED : RUN;
        else if (active && stall_nxt == SW'(TIMEOUT_CYC))
            state_nxt = TIMEOUT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            halted  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            halted  <= state_nxt == HALTED;
            timeout <= state_nxt == TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            insn_cnt  <= '0;
            cycle_cnt <= '0;
            signature <= SIG_SEED;
            wr_ptr    <= '0;
            trace_cnt <= '0;
            rep       <= '0;
            stall     <= '0;
            last_pc   <= '0;
            last_vld  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) trace[i] <= '0;
        end else if (bus.clr) begin
            insn_cnt  <= '0;
            cycle_cnt <= '0;
            signature <= SIG_SEED;
            wr_ptr    <= '0;
            trace_cnt <= '0;
            rep       <= '0;
            stall     <= '0;
            last_pc   <= '0;
            last_vld  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) trace[i] <= '0;
        end else begin
            if (active)
                cycle_cnt <= cycle_cnt + {{(CNT_W-1){1'b0}}, ~&cycle_cnt};
            if (count) begin
                insn_cnt      <= insn_cnt + {{(CNT_W-1){1'b0}}, ~&insn_cnt};
                signature     <= {signature[PC_W-2:0], signature[PC_W-1]} ^ bus.pc;
                trace[wr_ptr] <= bus.pc;
                wr_ptr        <= wr_ptr + 1'b1;
                trace_cnt     <= trace_cnt + {{IW{1'b0}}, trace_cnt != (IW+1)'(DEPTH)};
                stall         <= '0;
                rep           <= rep_nxt;
                last_pc       <= bus.pc;
                last_vld      <= 1'b1;
            end else if (active) begin
                stall <= stall_nxt;
            end
        end
    end

    assign rd_ptr        = wr_ptr - 1'b1 - bus.trace_idx;
    assign bus.trace_pc  = ({1'b0, bus.trace_idx} >= trace_cnt) ? '0 : trace[rd_ptr];
    assign bus.state     = state;
    assign bus.halted    = halted;
    assign bus.timeout   = timeout;
    assign bus.insn_cnt  = insn_cnt;
    assign bus.cycle_cnt = cycle_cnt;
    assign bus.signature = signature;
    assign bus.trace_cnt = trace_cnt;
endmodule

// File: tb/tb_commit_trace_monitor.sv
// tb_commit_trace_monitor: directed vector table plus hand-written halt, timeout, wrap and reset sequences
module tb_commit_trace_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails = 0;

    commit_trace_monitor_if #(.PC_W(32), .DEPTH(8), .CNT_W(32)) bus ();

    commit_trace_monitor #(
        .PC_W(32), .DEPTH(8), .CNT_W(32), .HALT_REPEAT(4), .TIMEOUT_CYC(16), .SIG_SEED(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        vld;
        logic [31:0] pc;
        logic [1:0]  st;
        logic [31:0] insn;
        logic [31:0] sig;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idx_chk(input string name, input int idx, input logic [31:0] exp);
        bus.trace_idx = 3'(idx);
        #1;
        chk(name, {32'h0, bus.trace_pc}, {32'h0, exp});
    endtask

    task automatic clear();
        bus.clr = 1'b1;
        bus.insn_vld = 1'b0;
        step();
        bus.clr = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc);
        bus.insn_vld = 1'b1;
        bus.pc = pc;
        step();
        bus.insn_vld = 1'b0;
    endtask

    initial begin
        bus.clr = 1'b0;
        bus.insn_vld = 1'b0;
        bus.pc = '0;
        bus.trace_idx = '0;
        vecs[0] = '{1'b1, 1'b0, 32'h0,  2'b00, 32'd0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h4,  2'b01, 32'd1, 32'h4};
        vecs[2] = '{1'b0, 1'b1, 32'h8,  2'b01, 32'd2, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 32'h10, 2'b01, 32'd3, 32'h10};
        vecs[4] = '{1'b0, 1'b1, 32'h10, 2'b01, 32'd4, 32'h30};
        vecs[5] = '{1'b0, 1'b0, 32'h0,  2'b01, 32'd4, 32'h30};
        vecs[6] = '{1'b0, 1'b1, 32'h14, 2'b01, 32'd5, 32'h74};

        // reset held for three cycles
        repeat (3) step();
        chk("rst_state", {62'h0, bus.state}, 64'h0);
        chk("rst_insn", {32'h0, bus.insn_cnt}, 64'h0);
        chk("rst_cycle", {32'h0, bus.cycle_cnt}, 64'h0);
        chk("rst_sig", {32'h0, bus.signature}, 64'h0);
        chk("rst_tcnt", {60'h0, bus.trace_cnt}, 64'h0);
        for (int i = 0; i < 8; i++) idx_chk($sformatf("rst_trace%0d", i), i, 32'h0);
        bus.trace_idx = '0;
        rst = 1'b0;

        // vector table: signature and counting
        for (int i = 0; i < 7; i++) begin
            bus.clr = vecs[i].clr;
            bus.insn_vld = vecs[i].vld;
            bus.pc = vecs[i].pc;
            step();
            chk($sformatf("vec%0d_state", i), {62'h0, bus.state}, {62'h0, vecs[i].st});
            chk($sformatf("vec%0d_insn", i), {32'h0, bus.insn_cnt}, {32'h0, vecs[i].insn});
            chk($sformatf("vec%0d_sig", i), {32'h0, bus.signature}, {32'h0, vecs[i].sig});
        end
        bus.clr = 1'b0;
        bus.insn_vld = 1'b0;

        // halt on the fourth repeat of 0x1C
        clear();
        for (int k = 0; k < 8; k++) retire(32'(4 * k));
        for (int k = 0; k < 4; k++) begin
            if (k == 3) chk("pre_halt_state", {62'h0, bus.state}, 64'h1);
            retire(32'h1C);
        end
        chk("halt_state", {62'h0, bus.state}, 64'h2);
        chk("halt_flag", {63'h0, bus.halted}, 64'h1);
        chk("halt_insn", {32'h0, bus.insn_cnt}, 64'd12);
        idx_chk("halt_idx0", 0, 32'h1C);
        idx_chk("halt_idx4", 4, 32'h1C);
        idx_chk("halt_idx5", 5, 32'h18);
        idx_chk("halt_idx7", 7, 32'h10);
        bus.trace_idx = '0;
        for (int k = 0; k < 3; k++) retire(32'h40);
        repeat (20) step();
        chk("frz_state", {62'h0, bus.state}, 64'h2);
        chk("frz_insn", {32'h0, bus.insn_cnt}, 64'd12);
        chk("frz_cycle", {32'h0, bus.cycle_cnt}, 64'd12);
        chk("frz_tcnt", {60'h0, bus.trace_cnt}, 64'd8);
        idx_chk("frz_idx0", 0, 32'h1C);

        // stall timeout after 16 idle edges
        clear();
        retire(32'h40);
        retire(32'h44);
        repeat (15) step();
        chk("to15_state", {62'h0, bus.state}, 64'h1);
        chk("to15_flag", {63'h0, bus.timeout}, 64'h0);
        step();
        chk("to16_state", {62'h0, bus.state}, 64'h3);
        chk("to16_flag", {63'h0, bus.timeout}, 64'h1);
        chk("to16_halt", {63'h0, bus.halted}, 64'h0);
        chk("to16_insn", {32'h0, bus.insn_cnt}, 64'd2);
        chk("to16_cycle", {32'h0, bus.cycle_cnt}, 64'd18);
        for (int k = 0; k < 3; k++) retire(32'h50);
        chk("tofrz_insn", {32'h0, bus.insn_cnt}, 64'd2);
        chk("tofrz_cycle", {32'h0, bus.cycle_cnt}, 64'd18);
        chk("tofrz_state", {62'h0, bus.state}, 64'h3);

        // trace wrap
        clear();
        for (int k = 0; k < 10; k++) begin
            retire(32'(32'h100 + 4 * k));
            if (k == 2) begin
                chk("part_tcnt", {60'h0, bus.trace_cnt}, 64'd3);
                idx_chk("part_idx2", 2, 32'h100);
                idx_chk("part_idx3", 3, 32'h0);
            end
        end
        chk("wrap_tcnt", {60'h0, bus.trace_cnt}, 64'd8);
        chk("wrap_insn", {32'h0, bus.insn_cnt}, 64'd10);
        idx_chk("wrap_idx0", 0, 32'h124);
        idx_chk("wrap_idx7", 7, 32'h108);
        bus.trace_idx = '0;

        // asynchronous reset mid-RUN, between edges
        #2 rst = 1'b1;
        #1;
        chk("arst_state", {62'h0, bus.state}, 64'h0);
        chk("arst_insn", {32'h0, bus.insn_cnt}, 64'h0);
        chk("arst_sig", {32'h0, bus.signature}, 64'h0);
        chk("arst_tcnt", {60'h0, bus.trace_cnt}, 64'h0);
        idx_chk("arst_idx0", 0, 32'h0);
        #1 rst = 1'b0;

        // clear out of HALTED
        clear();
        for (int k = 0; k < 5; k++) retire(32'h80);
        chk("h2_state", {62'h0, bus.state}, 64'h2);
        clear();
        chk("clr_state", {62'h0, bus.state}, 64'h0);
        chk("clr_halt", {63'h0, bus.halted}, 64'h0);
        chk("clr_insn", {32'h0, bus.insn_cnt}, 64'h0);
        chk("clr_cycle", {32'h0, bus.cycle_cnt}, 64'h0);
        chk("clr_sig", {32'h0, bus.signature}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
